// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - windowed saturating accumulator for MAC results
// Sums N terms per window, presents the sum on a valid/ready port, absorbs one early term.
module psum_accumulator #(
   parameter int N     = 9,
   parameter int IN_W  = 10,
   parameter int ACC_W = 14,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mac_valid,
   input  logic [IN_W-1:0]  mac_data,
   output logic             res_valid,
   output logic [ACC_W-1:0] res_data,
   input  logic             res_ready,
   output logic             res_sat,
   output logic             busy,
   output logic [CNT_W-1:0] term_cnt,
   output logic             drop_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state, state_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic             sat, sat_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             pend_v, pend_v_n;
   logic [IN_W-1:0]  pend_d, pend_d_n;
   logic             drop, drop_n;
   logic             valid_q, busy_q;

   // Top bit of the result flags an overflow; the value is already clamped.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [IN_W-1:0]  d);
      logic [ACC_W:0] s;
      s = {1'b0, a} + (ACC_W+1)'(d);
      if (s[ACC_W])
         return {1'b1, {ACC_W{1'b1}}};
      return s;
   endfunction

   logic [ACC_W-1:0] base_acc;
   logic [CNT_W-1:0] base_cnt;
   logic             hold_mac;
   logic             take_mac;
   logic [ACC_W:0]   r_sum;
   logic [ACC_W-1:0] r_acc;
   logic             r_sat;
   logic [CNT_W-1:0] r_cnt;
   logic [ACC_W:0]   a_sum;
   logic [CNT_W-1:0] cnt_inc;

   // Restart value: pending term (only ever held in DONE) first, then the live term.
   // With N = 1 a pending term already fills the window, so the live term is held instead.
   always_comb begin
      base_acc = pend_v ? ACC_W'(pend_d) : '0;
      base_cnt = pend_v ? ONE : '0;
      hold_mac = pend_v && (LAST == ONE);
      take_mac = mac_valid && !hold_mac;
      r_sum    = sat_add(base_acc, mac_data);
      r_acc    = take_mac ? r_sum[ACC_W-1:0] : base_acc;
      r_sat    = take_mac && r_sum[ACC_W];
      r_cnt    = base_cnt + (take_mac ? ONE : '0);
      a_sum    = sat_add(acc, mac_data);
      cnt_inc  = cnt + ONE;
   end

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      sat_n    = sat;
      cnt_n    = cnt;
      pend_v_n = pend_v;
      pend_d_n = pend_d;
      drop_n   = drop;
      if (start && (state != S_DONE || res_ready)) begin
         acc_n    = r_acc;
         sat_n    = r_sat;
         cnt_n    = r_cnt;
         drop_n   = 1'b0;
         pend_v_n = hold_mac && mac_valid;
         pend_d_n = mac_data;
         state_n  = (r_cnt == LAST) ? S_DONE : S_ACC;
      end else begin
         case (state)
            S_IDLE: begin
               if (mac_valid)
                  drop_n = 1'b1;
            end
            S_ACC: begin
               if (mac_valid) begin
                  acc_n = a_sum[ACC_W-1:0];
                  sat_n = sat | a_sum[ACC_W];
                  cnt_n = cnt_inc;
                  if (cnt_inc == LAST)
                     state_n = S_DONE;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  state_n  = S_IDLE;
                  pend_v_n = 1'b0;
                  if (pend_v || mac_valid)
                     drop_n = 1'b1;
               end else if (mac_valid) begin
                  if (pend_v) begin
                     drop_n = 1'b1;
                  end else begin
                     pend_v_n = 1'b1;
                     pend_d_n = mac_data;
                  end
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         acc     <= '0;
         sat     <= 1'b0;
         cnt     <= '0;
         pend_v  <= 1'b0;
         pend_d  <= '0;
         drop    <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         sat     <= sat_n;
         cnt     <= cnt_n;
         pend_v  <= pend_v_n;
         pend_d  <= pend_d_n;
         drop    <= drop_n;
         valid_q <= (state_n == S_DONE);
         busy_q  <= (state_n != S_IDLE);
      end
   end

   assign res_valid = valid_q;
   assign res_data  = acc;
   assign res_sat   = sat;
   assign busy      = busy_q;
   assign term_cnt  = cnt;
   assign drop_err  = drop;

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream consumer of the MAC stage's result stream. Accumulates N consecutive 10-bit MAC results (`out_valid`/`out`) into one partial sum, for example one 3x3 kernel window. It presents that sum on a valid/ready result port and absorbs one early MAC result while the previous sum is stalled. Saturation, term count and dropped-result errors are reported alongside the result.

## Interface
- `N`, default 9: terms per window; legal range 1..(2^CNT_W − 1).
- `IN_W`, default 10: MAC result width.
- `ACC_W`, default 14: accumulator/result width; must be ≥ IN_W.
- `CNT_W`, default 4: term counter width.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: opens a new window (clear and begin); single-cycle pulse.
- `mac_valid`, in, 1: MAC result strobe; connects to MAC `out_valid`.
- `mac_data`, in, IN_W: MAC result, unsigned; connects to MAC `out`.
- `res_valid`, out, 1: final window sum available.
- `res_data`, out, ACC_W: final window sum, unsigned.
- `res_ready`, in, 1: consumer accepts the result.
- `res_sat`, out, 1: the current/last window saturated; valid with `res_valid`.
- `busy`, out, 1: high in ACC and DONE.
- `term_cnt`, out, CNT_W: terms accumulated in the current window.
- `drop_err`, out, 1: sticky; set when a MAC result was discarded; cleared only by `start` or reset.

## Operation
- States: IDLE, ACC, DONE.
- **IDLE**
  - `mac_valid` without `start`: result discarded, `drop_err` set.
  - `start`: go to ACC with acc = 0, cnt = 0, `res_sat` = 0, `drop_err` = 0.
  - If `mac_valid` is high in the same cycle as `start`, that term is the first term: acc = mac_data, cnt = 1.
- **ACC**
  - Each `mac_valid`: acc = sat(acc + mac_data), cnt += 1.
  - The term making cnt == N moves the block to DONE.
  - `start` in ACC aborts the window: restart exactly as from IDLE, no result emitted, same-cycle `mac_valid` counts as term 1.
- **DONE**
  - `res_valid` = 1; `res_data` holds acc; `res_sat` holds the saturation flag.
  - Handshake is `res_valid & res_ready`.
  - Handshake without `start`: go to IDLE. Any pending entry is discarded and sets `drop_err`.
  - Handshake with `start`: go to ACC.
    - The pending entry (if any) becomes term 1 and same-cycle `mac_valid` the next term, with sat-add.
    - If no pending entry, same-cycle `mac_valid` becomes term 1.
    - If cnt reaches N this way (N = 1 or 2), go straight back to DONE.
  - `start` without handshake: ignored.
  - `mac_valid` without handshake: captured into the one-entry pending register if it is empty; otherwise discarded and `drop_err` set.
- **Arithmetic**
  - Unsigned, zero-extended to ACC_W+1 bits.
  - If the sum exceeds 2^ACC_W − 1, clamp to 2^ACC_W − 1 and set `res_sat` for the window.
  - Once saturated, acc stays clamped for the rest of the window.
- **N = 1:** a start+mac_valid cycle produces DONE in the next cycle.

## Timing
- Reset values: state IDLE, acc 0, cnt 0, pending empty, `res_valid` 0, `res_data` 0, `res_sat` 0, `busy` 0, `term_cnt` 0, `drop_err` 0.
- All outputs are registered.
- `res_valid` rises in the cycle after the Nth `mac_valid` is sampled.
- `res_valid` falls in the cycle after the handshake, unless the block re-enters DONE.
- `res_data` and `res_sat` are stable while `res_valid` = 1; they may be left unchanged after the handshake.
- The block sustains one term per cycle; the MAC delivers at most one term per 4 cycles.
- The pending register therefore covers one MAC period of result back-pressure.
- `term_cnt` and `busy` update in the cycle after the triggering edge.
- Reset asserted mid-window: immediate return to reset values; no partial result is emitted after release.

## Test plan
- Default parameters; `start`, then nine `mac_valid` with data 225, four cycles apart; `res_ready` = 1 → `res_valid` for 1 cycle, `res_data` = 2025, `res_sat` = 0, `term_cnt` = 9, then IDLE.
- ACC_W = 10; nine terms of 225 → `res_data` = 1023, `res_sat` = 1.
- Hold `res_ready` = 0 in DONE; send `mac_valid` with data 7; then `start` + `res_ready` together, followed by eight terms of 1 → second result `res_data` = 15, `drop_err` = 0.
- In DONE with `res_ready` = 0, send two `mac_valid` → `drop_err` = 1; handshake without `start` → IDLE; next `start` clears `drop_err`.
- `start`, four terms of 50, `start` again, then nine terms of 10 → exactly one result, `res_data` = 90.
- Assert `rst_n` = 0 after five terms; release; `mac_valid` in IDLE → no `res_valid`, `drop_err` = 1, all other outputs 0.
